// File: rtl/uart_rx_fifo_read_ctrl_if.sv
// Bundle of the FIFO read-port, empty-flag and processor byte handshake signals
// between the UART RX FIFO read controller (master) and its surroundings (slave).
interface uart_rx_fifo_read_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    logic                  comp_empty;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH-1:0] r_add;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] r_add_gray;
    logic [DATA_WIDTH-1:0] proc_data;
    logic                  proc_valid;
    logic                  proc_ready;
    logic [CNT_WIDTH-1:0]  rx_count;
    logic [1:0]            dbg_state;

    // proc_valid/proc_ready: a byte transfers on an edge where both are high;
    // once proc_valid rises, it and proc_data hold until that edge.
    modport master (
        input  comp_empty, rd_data, proc_ready,
        output r_add, rd_en, r_add_gray, proc_data, proc_valid, rx_count, dbg_state
    );

    modport slave (
        output comp_empty, rd_data, proc_ready,
        input  r_add, rd_en, r_add_gray, proc_data, proc_valid, rx_count, dbg_state
    );
endinterface

// File: rtl/uart_rx_fifo_read_ctrl.sv
// Processor-domain read controller of the UART RX async FIFO: reads one byte at
// a time from the RAM, hands it to the processor and exports a Gray read pointer.
module uart_rx_fifo_read_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        processor_clk,
    input  logic                        reset,
    uart_rx_fifo_read_ctrl_if.master    bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        PRESENT = 2'd3
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] r_add_q;
    logic [ADDR_WIDTH-1:0] r_add_gray_q;
    logic                  rd_en_q;
    logic [DATA_WIDTH-1:0] proc_data_q;
    logic                  proc_valid_q;
    logic [CNT_WIDTH-1:0]  rx_count_q;

    always_ff @(posedge processor_clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            r_add_q      <= '0;
            r_add_gray_q <= '0;
            rd_en_q      <= 1'b0;
            proc_data_q  <= '0;
            proc_valid_q <= 1'b0;
            rx_count_q   <= '0;
        end else begin
            // Gray pointer follows the binary address one cycle behind.
            r_add_gray_q <= r_add_q ^ (r_add_q >> 1);
            case (state_q)
                IDLE: begin
                    rd_en_q      <= 1'b0;
                    proc_valid_q <= 1'b0;
                    if (!bus.comp_empty) begin
                        state_q <= READ;
                        rd_en_q <= 1'b1;
                    end
                end
                READ: begin
                    rd_en_q <= 1'b0;
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    proc_data_q  <= bus.rd_data;
                    proc_valid_q <= 1'b1;
                    r_add_q      <= r_add_q + 1'b1;
                    state_q      <= PRESENT;
                end
                PRESENT: begin
                    if (bus.proc_ready) begin
                        proc_valid_q <= 1'b0;
                        rx_count_q   <= rx_count_q + 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.r_add      = r_add_q;
    assign bus.r_add_gray = r_add_gray_q;
    assign bus.rd_en      = rd_en_q;
    assign bus.proc_data  = proc_data_q;
    assign bus.proc_valid = proc_valid_q;
    assign bus.rx_count   = rx_count_q;
    assign bus.dbg_state  = state_q;
endmodule
